delay_ctrl: RTL and testbench
=============================

# delay_ctrl

Run-time configurable delay line with a load/refill sequencer, used where a stream must be aligned against another path whose latency is only known after configuration. It holds a MAX_CYCLES-deep register chain with per-stage valid bits and taps the output at the programmed depth. A small state machine sequences reconfiguration: it flushes stale samples, reports `busy` until the chain has refilled at the new depth, then runs.

## Interface
- NUM_BITS, 16: width of the data word.
- MAX_CYCLES, 16: number of register stages. Maximum latency is MAX_CYCLES cycles.
- DELAY_WIDTH, 4: width of the delay fields. Must satisfy 2^DELAY_WIDTH ≥ MAX_CYCLES.

- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- din  input  NUM_BITS  sample in.
- din_valid  input  1  qualifies `din` this cycle.
- cfg_delay  input  DELAY_WIDTH  requested tap index D; latency is D+1 cycles.
- cfg_load  input  1  single-cycle strobe; applies `cfg_delay`.
- dout  output  NUM_BITS  delayed sample; 0 when `dout_valid` is low.
- dout_valid  output  1  qualifies `dout`.
- busy  output  1  high while flushing/refilling.
- active_delay  output  DELAY_WIDTH  tap index currently in effect.

## Operation
- Datapath: stages data[0..MAX_CYCLES-1] and vld[0..MAX_CYCLES-1].
  - Each edge: data[0] <= din_valid ? din : 0 and vld[0] <= din_valid.
  - For i ≥ 1: data[i] <= data[i-1] and vld[i] <= vld[i-1].
- Tap: `dout` = data[active_delay] and `dout_valid` = vld[active_delay], each gated by state == RUN. Both outputs are combinational from registers.
- Clamp: a `cfg_delay` value ≥ MAX_CYCLES is loaded as MAX_CYCLES-1.
- FSM states:
  - IDLE: entered after reset. `busy`=0, `dout_valid`=0. The chain still shifts.
  - FILL: entered on `cfg_load` from any state. `busy`=1, `dout_valid`=0.
  - RUN: `busy`=0. Tap is live.
- cfg_load, in any state, on the same edge:
  - All vld[] and data[] are cleared to 0.
  - `active_delay` <= clamped `cfg_delay`.
  - Fill counter cnt <= 0.
  - State <= FILL.
- FILL: cnt increments each edge. When cnt == active_delay, the next state is RUN. FILL therefore lasts exactly active_delay+1 cycles.
- RUN: remains in RUN until `cfg_load` or reset.
- Simultaneous `cfg_load` and `din_valid`: the sample on that cycle is discarded (vld[0] <= 0). No sample from before the load ever reaches `dout`.
- A `cfg_load` during FILL restarts FILL with the new value. cnt returns to 0.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces:
  - state=IDLE, cnt=0, all data/vld=0
  - `dout`=0, `dout_valid`=0, `busy`=0, `active_delay`=0
- Reset asserted mid-FILL or mid-RUN takes effect immediately, without waiting for a clock edge.
- Latency in RUN: a sample with `din_valid`=1 at edge k appears on `dout` with `dout_valid`=1 in the cycle after edge k+D. That is D+1 cycles, where D = `active_delay`.
- Throughput: one sample per cycle. Gaps in `din_valid` are preserved exactly at the output.
- `busy` rises in the cycle after the `cfg_load` edge and falls after D+1 further edges. The first post-load sample can be presented in the first FILL cycle.
- D=0: FILL lasts 1 cycle. Latency is 1 cycle.
- D=MAX_CYCLES-1: the output tap is the last stage.
- `active_delay` changes only on the `cfg_load` edge or on reset.

## Test plan
- Reset/idle: hold `reset`=0, then release and drive din_valid=1, din=0x1234 for 20 cycles with no load. Required: `dout_valid`=0, `busy`=0 and `active_delay`=0 throughout.
- Basic delay: load D=3, then stream din=1,2,3… with `din_valid`=1 every cycle. Required: `busy` high for exactly 4 cycles. Value 1 appears on `dout` 4 cycles after it is presented, then a contiguous stream follows.
- Gaps and clamp: load cfg_delay=15 with MAX_CYCLES=16, then send samples 0xA, idle, idle, 0xB. Required: `active_delay`=15 and latency 16. `dout_valid` shows the pattern 1,0,0,1.
- Reconfigure mid-stream: in RUN with D=5, pulse `cfg_load` with D=1 while `din_valid`=1. Required: that cycle's sample is never output and no pre-load sample appears. `busy` is high for 2 cycles, then new samples emerge at latency 2.
- Reload during FILL: load D=8, then reload D=2 three cycles later. Required: `busy` stays high continuously and ends 3 cycles after the second load. `active_delay`=2.
- Asynchronous reset mid-RUN: assert `reset`=0 between clock edges. Required: `dout_valid`, `busy` and `dout` go to 0 immediately and `active_delay`=0. After release, the block stays in IDLE until the next `cfg_load`.

Source files
------------

// File: rtl/delay_ctrl.sv
// Run-time configurable delay line: a MAX_CYCLES-deep register chain tapped at
// active_delay, with an IDLE/FILL/RUN sequencer that flushes and refills on cfg_load.
module delay_ctrl #(
    parameter int NUM_BITS    = 16,
    parameter int MAX_CYCLES  = 16,
    parameter int DELAY_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BITS-1:0]    din,
    input  logic                   din_valid,
    input  logic [DELAY_WIDTH-1:0] cfg_delay,
    input  logic                   cfg_load,
    output logic [NUM_BITS-1:0]    dout,
    output logic                   dout_valid,
    output logic                   busy,
    output logic [DELAY_WIDTH-1:0] active_delay,
    output logic [1:0]             state_dbg
);

    // Stream qualification is valid-only: din is captured on every edge where
    // din_valid is high, there is no backpressure, and dout is meaningful only
    // while dout_valid is high (dout reads 0 otherwise).

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state;
    logic [DELAY_WIDTH-1:0] cnt;
    logic [DELAY_WIDTH-1:0] delay_clamped;
    logic [NUM_BITS-1:0]    data [MAX_CYCLES];
    logic [MAX_CYCLES-1:0]  vld;

    always_comb begin
        delay_clamped = cfg_delay;
        if (32'(cfg_delay) >= MAX_CYCLES)
            delay_clamped = DELAY_WIDTH'(MAX_CYCLES - 1);
    end

    // A load flushes the chain, so the sample presented on the load cycle is dropped too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < MAX_CYCLES; i++)
                data[i] <= '0;
        end else if (cfg_load) begin
            vld <= '0;
            for (int i = 0; i < MAX_CYCLES; i++)
                data[i] <= '0;
        end else begin
            vld     <= {vld[MAX_CYCLES-2:0], din_valid};
            data[0] <= din_valid ? din : '0;
            for (int i = 1; i < MAX_CYCLES; i++)
                data[i] <= data[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            active_delay <= '0;
            busy         <= 1'b0;
        end else if (cfg_load) begin
            state        <= FILL;
            cnt          <= '0;
            active_delay <= delay_clamped;
            busy         <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    cnt <= cnt + 1'b1;
                    // The chain holds active_delay+1 fresh stages once cnt reaches the tap.
                    if (cnt == active_delay) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN:     busy  <= 1'b0;
                default: busy  <= 1'b0;
            endcase
        end
    end

    always_comb begin
        dout       = '0;
        dout_valid = 1'b0;
        if (state == RUN) begin
            dout       = data[active_delay];
            dout_valid = vld[active_delay];
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed bench for delay_ctrl: inputs change on the falling edge, outputs are
// checked on the falling edge before new inputs are applied.
module tb_delay_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic [3:0]  cfg_delay = '0;
    logic        cfg_load = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        busy;
    logic [3:0]  active_delay;
    logic [1:0]  state_dbg;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    localparam logic [1:0] ST_IDLE = 2'd0;

    delay_ctrl #(.NUM_BITS(16), .MAX_CYCLES(16), .DELAY_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_delay(cfg_delay), .cfg_load(cfg_load), .dout(dout),
        .dout_valid(dout_valid), .busy(busy), .active_delay(active_delay),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dout, dout_valid, busy, active_delay, state_dbg} !== {16'h0, 1'b0, 1'b0, 4'h0, ST_IDLE}) begin
            n_err++;
            $display("FAIL reset_state got dout=%h v=%b busy=%b ad=%0d st=%0d expected all 0",
                     dout, dout_valid, busy, active_delay, state_dbg);
        end
        reset = 1'b1; din_valid = 1'b1; din = 16'h1234;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({dout_valid, busy, active_delay, dout} !== {1'b0, 1'b0, 4'h0, 16'h0}) begin
                n_err++;
                $display("FAIL idle_no_load j=%0d got v=%b busy=%b ad=%0d dout=%h expected 0,0,0,0",
                         j, dout_valid, busy, active_delay, dout);
            end
        end
    endtask

    task automatic test_basic_delay();
        logic [15:0] exp;
        int          busy_cnt = 0;
        @(negedge clk);
        cfg_delay = 4'd3; cfg_load = 1'b1; din_valid = 1'b0;
        exp_q.delete();
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            cfg_load = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            n_cmp++;
            if (busy !== 1'(j < 4)) begin
                n_err++;
                $display("FAIL basic_busy j=%0d got %b expected %b", j, busy, 1'(j < 4));
            end
            if (j >= 4) begin
                exp = exp_q.pop_front();
                n_cmp++;
                if ({dout_valid, dout} !== {1'b1, exp}) begin
                    n_err++;
                    $display("FAIL basic_data j=%0d got v=%b dout=%h expected 1,%h", j, dout_valid, dout, exp);
                end
            end else begin
                n_cmp++;
                if ({dout_valid, dout} !== {1'b0, 16'h0}) begin
                    n_err++;
                    $display("FAIL basic_fill_out j=%0d got v=%b dout=%h expected 0,0", j, dout_valid, dout);
                end
            end
            din_valid = 1'b1; din = 16'(j + 1);
            exp_q.push_back(16'(j + 1));
        end
        n_cmp++;
        if (busy_cnt != 4) begin
            n_err++;
            $display("FAIL basic_busy_len got %0d expected 4", busy_cnt);
        end
        n_cmp++;
        if (active_delay !== 4'd3) begin
            n_err++;
            $display("FAIL basic_active_delay got %0d expected 3", active_delay);
        end
    endtask

    task automatic test_gaps_clamp();
        logic [15:0] exp_d;
        logic        exp_v;
        @(negedge clk);
        cfg_delay = 4'd15; cfg_load = 1'b1; din_valid = 1'b0;
        for (int j = 0; j < 21; j++) begin
            @(negedge clk);
            cfg_load = 1'b0;
            exp_v = (j == 16) || (j == 19);
            exp_d = (j == 16) ? 16'h000A : (j == 19) ? 16'h000B : 16'h0000;
            n_cmp++;
            if ({dout_valid, dout, busy, active_delay} !== {exp_v, exp_d, 1'(j < 16), 4'd15}) begin
                n_err++;
                $display("FAIL gaps_clamp j=%0d got v=%b dout=%h busy=%b ad=%0d expected %b,%h,%b,15",
                         j, dout_valid, dout, busy, active_delay, exp_v, exp_d, 1'(j < 16));
            end
            din_valid = (j == 0) || (j == 3);
            din = (j == 0) ? 16'h000A : (j == 3) ? 16'h000B : 16'hFFFF;
        end
    endtask

    task automatic test_reconfig_midstream();
        logic [15:0] exp_d;
        @(negedge clk);
        cfg_delay = 4'd5; cfg_load = 1'b1; din_valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            cfg_load = 1'b0;
            din_valid = 1'b1; din = 16'(16'h0100 + j);
        end
        @(negedge clk);
        n_cmp++;
        if ({dout_valid, dout} !== {1'b1, 16'h0104}) begin
            n_err++;
            $display("FAIL reconfig_pre_run got v=%b dout=%h expected 1,0104", dout_valid, dout);
        end
        cfg_delay = 4'd1; cfg_load = 1'b1; din_valid = 1'b1; din = 16'hDEAD;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            cfg_load = 1'b0;
            exp_d = (j >= 2) ? 16'(16'h0200 + j - 2) : 16'h0000;
            n_cmp++;
            if ({busy, dout_valid, dout, active_delay} !== {1'(j < 2), 1'(j >= 2), exp_d, 4'd1}) begin
                n_err++;
                $display("FAIL reconfig j=%0d got busy=%b v=%b dout=%h ad=%0d expected %b,%b,%h,1",
                         j, busy, dout_valid, dout, active_delay, 1'(j < 2), 1'(j >= 2), exp_d);
            end
            din_valid = 1'b1; din = 16'(16'h0200 + j);
        end
    endtask

    task automatic test_reload_during_fill();
        logic [15:0] exp_d;
        logic [3:0]  exp_ad;
        @(negedge clk);
        cfg_delay = 4'd8; cfg_load = 1'b1; din_valid = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            cfg_load = 1'b0;
            exp_ad = (j < 3) ? 4'd8 : 4'd2;
            exp_d  = (j >= 6) ? 16'(16'h0300 + j - 3) : 16'h0000;
            n_cmp++;
            if ({busy, active_delay, dout_valid, dout} !== {1'(j < 6), exp_ad, 1'(j >= 6), exp_d}) begin
                n_err++;
                $display("FAIL reload_fill j=%0d got busy=%b ad=%0d v=%b dout=%h expected %b,%0d,%b,%h",
                         j, busy, active_delay, dout_valid, dout, 1'(j < 6), exp_ad, 1'(j >= 6), exp_d);
            end
            if (j == 2) begin
                cfg_delay = 4'd2; cfg_load = 1'b1; din_valid = 1'b0;
            end else if (j >= 3) begin
                din_valid = 1'b1; din = 16'(16'h0300 + j);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        n_cmp++;
        if ({dout_valid, dout, busy} !== {1'b1, 16'h0306, 1'b0}) begin
            n_err++;
            $display("FAIL areset_pre got v=%b dout=%h busy=%b expected 1,0306,0", dout_valid, dout, busy);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({dout_valid, dout, busy, active_delay, state_dbg} !== {1'b0, 16'h0, 1'b0, 4'h0, ST_IDLE}) begin
            n_err++;
            $display("FAIL areset_immediate got v=%b dout=%h busy=%b ad=%0d st=%0d expected all 0",
                     dout_valid, dout, busy, active_delay, state_dbg);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({dout_valid, dout, busy, active_delay, state_dbg} !== {1'b0, 16'h0, 1'b0, 4'h0, ST_IDLE}) begin
                n_err++;
                $display("FAIL areset_stays_idle j=%0d got v=%b dout=%h busy=%b ad=%0d st=%0d expected all 0",
                         j, dout_valid, dout, busy, active_delay, state_dbg);
            end
        end
    endtask

    task automatic test_zero_delay();
        logic [15:0] exp_d;
        @(negedge clk);
        cfg_delay = 4'd0; cfg_load = 1'b1; din_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            cfg_load = 1'b0;
            exp_d = (j >= 1) ? 16'(16'h0500 + j - 1) : 16'h0000;
            n_cmp++;
            if ({busy, dout_valid, dout} !== {1'(j == 0), 1'(j >= 1), exp_d}) begin
                n_err++;
                $display("FAIL zero_delay j=%0d got busy=%b v=%b dout=%h expected %b,%b,%h",
                         j, busy, dout_valid, dout, 1'(j == 0), 1'(j >= 1), exp_d);
            end
            din_valid = 1'b1; din = 16'(16'h0500 + j);
        end
    endtask

    initial begin
        test_reset();
        test_basic_delay();
        test_gaps_clamp();
        test_reconfig_midstream();
        test_reload_during_fill();
        test_async_reset();
        test_zero_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
